pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It takes hazard requests, branch redirects and data-memory wait requests, and produces every per-stage write-enable and flush signal through a small FSM. The hazard detection unit stays combinational and only reports conditions. This block decides priority and how long each stall lasts. It sits beside the pipeline registers and drives PCWrite, IF_ID_Write and the flush/bubble controls.

Parameters:
LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 15, maximum cycles spent in MEM_WAIT before the block aborts with mem_error (1..255)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
load_use_hazard  in  1  HDU request: ID_EX load destination matches IF_ID Rs1/Rs2
branch_taken_ID  in  1  branch/jump resolved taken in ID
dmem_req  in  1  EX/MEM stage is issuing a data-memory access this cycle
dmem_ready  in  1  data memory has completed the access
PCWrite  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  IF/ID register clear
Stall  out  1  insert bubble into ID/EX (zero control bits)
EX_MEM_Write  out  1  EX/MEM and MEM/WB register enable
mem_error  out  1  sticky flag: MEM_TIMEOUT expired
state_o  out  2  current FSM state, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - state = RUN, counters = 0, mem_error = 0.
  - Outputs during reset: PCWrite = 1, IF_ID_Write = 1, EX_MEM_Write = 1, IF_ID_Flush = 0, Stall = 0.
- FSM states: RUN = 0, LOAD_STALL = 1, MEM_WAIT = 2, FLUSH = 3.
- Outputs are combinational from state and current inputs, so a hazard stalls in the same cycle it is raised. The state register updates on the rising edge of clk.
- Priority each cycle, highest first:
  1. MEM_WAIT condition (dmem_req & ~dmem_ready).
  2. Load-use hazard.
  3. Branch taken.
- RUN:
  - dmem_req & ~dmem_ready: all enables 0 and Stall = 0 (whole pipeline frozen). Go to MEM_WAIT with timeout counter = 1.
  - Else load_use_hazard: PCWrite = 0, IF_ID_Write = 0, Stall = 1. If LOAD_STALL_CYCLES > 1, go to LOAD_STALL with counter = 1; otherwise stay in RUN. branch_taken_ID is ignored this cycle because its operands are stale.
  - Else branch_taken_ID: PCWrite = 1 (redirect), IF_ID_Flush = 1. Go to FLUSH.
  - Else all enables 1.
- LOAD_STALL:
  - Same outputs as the load-use stall in RUN.
  - The counter increments each cycle. When it reaches LOAD_STALL_CYCLES, go to RUN.
  - A memory wait takes precedence: go to MEM_WAIT. The remaining bubble count is preserved and resumed afterwards.
- MEM_WAIT:
  - All enables 0, Stall = 0, IF_ID_Flush = 0.
  - On dmem_ready: enables 1 in that same cycle, then return to the saved state (RUN, or LOAD_STALL with its count).
  - The counter increments each cycle. When counter == MEM_TIMEOUT and dmem_ready is still 0: set mem_error (sticky until reset), release the pipeline, go to RUN.
- FLUSH:
  - One cycle. IF_ID_Flush = 1 and Stall = 1 so the wrong-path fetch becomes a bubble. Go to RUN.
  - dmem_req & ~dmem_ready takes precedence: freeze and go to MEM_WAIT; the flush is re-applied after the wait.
- Simultaneous events:
  - load_use_hazard and branch_taken_ID both set: stall only, no flush.
  - branch_taken_ID while in LOAD_STALL: ignored.
- Reset mid-stall or mid-wait: returns immediately to RUN; all counts are discarded.
- Counter widths: 3 bits for the load-stall count, 8 bits for the timeout. The timeout counter saturates and never wraps.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined: adds outputs stall_cycles, flush_count and mem_wait_cycles, each CNT_W bits.
  - stall_cycles increments on every cycle with Stall = 1.
  - flush_count increments on entry to FLUSH.
  - mem_wait_cycles increments on every MEM_WAIT cycle.
  - All three saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encodings ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT, ST_FLUSH;
  - default parameter constants;
  - a control-bundle typedef {PCWrite, IF_ID_Write, IF_ID_Flush, Stall, EX_MEM_Write}.
- One natural sub-module: stall_timer, a loadable saturating counter with a terminal-count flag, instantiated twice (load-stall count and memory timeout).

Test Plan:
1. Post-reset idle, all inputs 0 → PCWrite = 1, IF_ID_Write = 1, EX_MEM_Write = 1, Stall = 0, state_o = 0.
2. With LOAD_STALL_CYCLES = 2, pulse load_use_hazard for 1 cycle → PCWrite = 0 and Stall = 1 for exactly 2 cycles, state_o = 1 in the second, then RUN.
3. branch_taken_ID = 1 for 1 cycle → IF_ID_Flush = 1 in that cycle and the next (FLUSH), Stall = 1 in the FLUSH cycle, then RUN.
4. load_use_hazard and branch_taken_ID together → Stall = 1 and IF_ID_Flush = 0; no FLUSH state is entered.
5. dmem_req = 1 with dmem_ready low for 5 cycles → all enables 0 for 5 cycles; on cycle 6 dmem_ready = 1 → enables 1, mem_error = 0.
6. dmem_ready held low with MEM_TIMEOUT = 15 → mem_error = 1 after 15 wait cycles and the pipeline releases. Then assert reset mid-LOAD_STALL → state_o = 0 immediately and mem_error = 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings, default parameter values, counter widths and the per-stage
// control bundle together with the few bundle values the FSM drives.
package pipe_ctrl_pkg;

  // Default parameter values for pipeline_stall_ctrl.
  localparam int LOAD_STALL_CYCLES_DEF = 1;
  localparam int MEM_TIMEOUT_DEF       = 15;
  localparam int CNT_W_DEF             = 16;

  // Internal counter widths: bubble count and memory-wait timeout.
  localparam int LS_CNT_W  = 3;
  localparam int TMO_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_e;

  // One bit per pipeline control the sequencer owns.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic stall;
    logic ex_mem_write;
  } ctrl_t;

  // Normal flow: every register advances.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                 stall: 1'b0, ex_mem_write: 1'b1};
  // Whole pipeline frozen while data memory is busy.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    stall: 1'b0, ex_mem_write: 1'b0};
  // Load-use bubble: hold PC and IF/ID, zero the ID/EX controls.
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    stall: 1'b0 | 1'b1, ex_mem_write: 1'b1};
  // Taken branch in ID: redirect the PC and clear the wrong-path fetch.
  localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                      stall: 1'b0, ex_mem_write: 1'b1};
  // FLUSH cycle: the wrong-path instruction now in ID becomes a bubble.
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                   stall: 1'b1, ex_mem_write: 1'b1};

endpackage

// File: rtl/stall_timer.sv
// Loadable saturating up-counter with a terminal-count flag. Used by the
// stall sequencer both as the load-use bubble counter and as the
// memory-wait timeout counter.
module stall_timer
  #(parameter int             W    = 8,
    parameter logic [W-1:0]   TERM = '1)
  (input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic         tc_o);

  logic [W-1:0] count_q, count_d;

  // Next count: load wins over increment; increment stops at all-ones.
  always_comb begin
    // NOTE: assigning the default first means every path drives count_d, so no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, avoiding simulation races.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TERM);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Arbitrates memory
// waits, load-use hazards and taken branches (in that priority) and drives the
// per-stage write enables, flush and bubble controls combinationally from the
// current state and inputs, so a hazard takes effect in the cycle it is raised.
// Optional build macro PIPE_PERF_CNT_EN adds saturating performance counters
// (stall_cycles, flush_count, mem_wait_cycles) and the CNT_W parameter.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
  #(parameter int LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
    parameter int MEM_TIMEOUT       = MEM_TIMEOUT_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W             = CNT_W_DEF
`endif
  )
  (input  logic       clk,
   input  logic       reset,
   input  logic       load_use_hazard,
   input  logic       branch_taken_ID,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   output logic       PCWrite,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       Stall,
   output logic       EX_MEM_Write,
   output logic       mem_error,
   output logic [1:0] state_o
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] mem_wait_cycles
`endif
  );

  // The bubble counter holds the number of bubbles already inserted, so the
  // stall ends in the cycle whose bubble brings the count to LOAD_STALL_CYCLES.
  localparam logic [LS_CNT_W-1:0]  LS_TERM  = LS_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0] TMO_TERM = TMO_CNT_W'(MEM_TIMEOUT);

  state_e state_q, state_d;
  state_e ret_q, ret_d;        // state to resume after a memory wait
  logic   mem_err_q, mem_err_d;
  ctrl_t  ctrl;

  logic mem_stall;
  logic ls_load, ls_inc, ls_tc;
  logic tmo_load, tmo_inc, tmo_tc;

  assign mem_stall = dmem_req & ~dmem_ready;

  stall_timer #(.W(LS_CNT_W), .TERM(LS_TERM)) u_load_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ls_load),
    .load_val_i (LS_CNT_W'(1)),
    .inc_i      (ls_inc),
    .tc_o       (ls_tc)
  );

  stall_timer #(.W(TMO_CNT_W), .TERM(TMO_TERM)) u_mem_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmo_load),
    .load_val_i (TMO_CNT_W'(1)),
    .inc_i      (tmo_inc),
    .tc_o       (tmo_tc)
  );

  // Next-state, resume-state and control-bundle decode.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    mem_err_d = mem_err_q;
    ctrl      = CTRL_RUN;
    ls_load   = 1'b0;
    ls_inc    = 1'b0;
    tmo_load  = 1'b0;
    tmo_inc   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl     = CTRL_FREEZE;
          state_d  = ST_MEM_WAIT;
          ret_d    = ST_RUN;
          tmo_load = 1'b1;
        end else if (load_use_hazard) begin
          // A simultaneous branch is dropped: its operands are stale.
          ctrl = CTRL_BUBBLE;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_LOAD_STALL;
            ls_load = 1'b1;
          end
        end else if (branch_taken_ID) begin
          ctrl    = CTRL_REDIRECT;
          state_d = ST_FLUSH;
        end
      end

      ST_LOAD_STALL: begin
        if (mem_stall) begin
          // Bubble count is held, so the stall resumes where it left off.
          ctrl     = CTRL_FREEZE;
          state_d  = ST_MEM_WAIT;
          ret_d    = ST_LOAD_STALL;
          tmo_load = 1'b1;
        end else begin
          ctrl   = CTRL_BUBBLE;
          ls_inc = 1'b1;
          if (ls_tc) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ret_q;
        end else if (tmo_tc) begin
          // Abort: flag the error, release the pipeline, drop pending work.
          mem_err_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          ctrl    = CTRL_FREEZE;
          tmo_inc = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (mem_stall) begin
          ctrl     = CTRL_FREEZE;
          state_d  = ST_MEM_WAIT;
          ret_d    = ST_FLUSH;
          tmo_load = 1'b1;
        end else begin
          ctrl    = CTRL_FLUSH;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Pipeline runs freely while reset is held, whatever the inputs say.
    if (reset) begin
      ctrl = CTRL_RUN;
    end
  end

  // State, resume-state and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign PCWrite      = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign IF_ID_Flush  = ctrl.if_id_flush;
  assign Stall        = ctrl.stall;
  assign EX_MEM_Write = ctrl.ex_mem_write;
  assign mem_error    = mem_err_q;
  assign state_o      = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memw_cnt_q;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      memw_cnt_q  <= '0;
    end else begin
      if (ctrl.stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
      if ((state_q == ST_MEM_WAIT) && (memw_cnt_q != '1)) begin
        memw_cnt_q <= memw_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign flush_count     = flush_cnt_q;
  assign mem_wait_cycles = memw_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model that
// tracks pending bubbles, pending flush and memory-wait length.
module tb_pipeline_stall_ctrl;

  localparam int LSC  = 2;
  localparam int MTO  = 15;

  // Expected control bundles {PCWrite, IF_ID_Write, IF_ID_Flush, Stall, EX_MEM_Write}.
  localparam logic [4:0] C_RUN    = 5'b11001;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_BUBBLE = 5'b00011;
  localparam logic [4:0] C_REDIR  = 5'b11101;
  localparam logic [4:0] C_FLUSH  = 5'b11111;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_use_hazard, branch_taken_ID, dmem_req, dmem_ready;
  logic       PCWrite, IF_ID_Write, IF_ID_Flush, Stall, EX_MEM_Write, mem_error;
  logic [1:0] state_o;
  logic [4:0] ctrl_vec;

  int total = 0;
  int bad   = 0;

  assign ctrl_vec = {PCWrite, IF_ID_Write, IF_ID_Flush, Stall, EX_MEM_Write};

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(LSC), .MEM_TIMEOUT(MTO)) dut (
    .clk             (clk),
    .reset           (rst),
    .load_use_hazard (load_use_hazard),
    .branch_taken_ID (branch_taken_ID),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .Stall           (Stall),
    .EX_MEM_Write    (EX_MEM_Write),
    .mem_error       (mem_error),
    .state_o         (state_o)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one input vector just after the rising edge, return at the falling edge.
  task automatic step(input logic luh, input logic br, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    load_use_hazard = luh;
    branch_taken_ID = br;
    dmem_req        = req;
    dmem_ready      = rdy;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [4:0] exp_ctrl, input logic [1:0] exp_state);
    check({name, "_ctrl"}, 8'(ctrl_vec), 8'(exp_ctrl));
    check({name, "_state"}, 8'(state_o), 8'(exp_state));
  endtask

  // Behavioural model: what is still owed to the pipeline.
  int         m_bubbles = 0;   // bubbles still to insert for the current load-use stall
  bit         m_flush   = 0;   // wrong-path bubble still to insert after a redirect
  bit         m_wait    = 0;   // inside a memory wait
  int         m_wait_n  = 0;   // cycles of the current wait, 1 on the first wait cycle
  bit         m_err     = 0;
  logic [4:0] m_ctrl;
  logic [1:0] m_state;

  always @(negedge clk) begin
    if (rst) begin
      m_bubbles = 0;
      m_flush   = 0;
      m_wait    = 0;
      m_wait_n  = 0;
      m_err     = 0;
      check("mdl_rst_ctrl", 8'(ctrl_vec), 8'(C_RUN));
      check("mdl_rst_state", 8'(state_o), 8'd0);
      check("mdl_rst_err", 8'(mem_error), 8'd0);
    end else begin
      m_state = m_wait ? 2'd2 : m_flush ? 2'd3 : (m_bubbles > 0) ? 2'd1 : 2'd0;
      check("mdl_state", 8'(state_o), 8'(m_state));
      check("mdl_err", 8'(mem_error), 8'(m_err));
      if (m_wait) begin
        if (dmem_ready) begin
          m_ctrl = C_RUN;
          m_wait = 0;
        end else if (m_wait_n == MTO) begin
          m_ctrl    = C_RUN;
          m_err     = 1;
          m_wait    = 0;
          m_bubbles = 0;
          m_flush   = 0;
        end else begin
          m_ctrl   = C_FREEZE;
          m_wait_n = m_wait_n + 1;
        end
      end else if (dmem_req && !dmem_ready) begin
        m_ctrl   = C_FREEZE;
        m_wait   = 1;
        m_wait_n = 1;
      end else if (m_flush) begin
        m_ctrl  = C_FLUSH;
        m_flush = 0;
      end else if (m_bubbles > 0) begin
        m_ctrl    = C_BUBBLE;
        m_bubbles = m_bubbles - 1;
      end else if (load_use_hazard) begin
        m_ctrl    = C_BUBBLE;
        m_bubbles = LSC - 1;
      end else if (branch_taken_ID) begin
        m_ctrl  = C_REDIR;
        m_flush = 1;
      end else begin
        m_ctrl = C_RUN;
      end
      check("mdl_ctrl", 8'(ctrl_vec), 8'(m_ctrl));
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat [8];
    pat = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0011, 4'b1100, 4'b0110, 4'b1010};

    // Reset with every request raised: outputs must still show free flow.
    rst             = 1'b1;
    load_use_hazard = 1'b1;
    branch_taken_ID = 1'b1;
    dmem_req        = 1'b1;
    dmem_ready      = 1'b0;
    #3;
    lit("reset", C_RUN, 2'd0);
    check("reset_err", 8'(mem_error), 8'd0);
    @(posedge clk);
    #1;
    load_use_hazard = 1'b0;
    branch_taken_ID = 1'b0;
    dmem_req        = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle
    step(0, 0, 0, 0); lit("idle", C_RUN, 2'd0);

    // 2: single load-use pulse gives exactly LSC=2 bubbles
    step(1, 0, 0, 0); lit("lu_c1", C_BUBBLE, 2'd0);
    step(0, 0, 0, 0); lit("lu_c2", C_BUBBLE, 2'd1);
    step(0, 0, 0, 0); lit("lu_done", C_RUN, 2'd0);

    // 3: taken branch -> redirect, then one FLUSH cycle
    step(0, 1, 0, 0); lit("br_c1", C_REDIR, 2'd0);
    step(0, 0, 0, 0); lit("br_flush", C_FLUSH, 2'd3);
    step(0, 0, 0, 0); lit("br_done", C_RUN, 2'd0);

    // 4: load-use and branch together -> stall only
    step(1, 1, 0, 0); lit("lubr_c1", C_BUBBLE, 2'd0);
    step(0, 0, 0, 0); lit("lubr_c2", C_BUBBLE, 2'd1);
    step(0, 0, 0, 0); lit("lubr_done", C_RUN, 2'd0);

    // 5: five frozen cycles, ready on the sixth
    step(0, 0, 1, 0); lit("mw_c1", C_FREEZE, 2'd0);
    for (int i = 2; i <= 5; i++) begin
      step(0, 0, 1, 0); lit("mw_hold", C_FREEZE, 2'd2);
    end
    step(0, 0, 1, 1); lit("mw_ready", C_RUN, 2'd2);
    step(0, 0, 0, 0); lit("mw_done", C_RUN, 2'd0);
    check("mw_err", 8'(mem_error), 8'd0);

    // Memory wait during FLUSH: flush re-applied afterwards
    step(0, 1, 0, 0); lit("fw_br", C_REDIR, 2'd0);
    step(0, 0, 1, 0); lit("fw_frz", C_FREEZE, 2'd3);
    step(0, 0, 1, 0); lit("fw_wait", C_FREEZE, 2'd2);
    step(0, 0, 1, 1); lit("fw_rdy", C_RUN, 2'd2);
    step(0, 0, 0, 0); lit("fw_flush", C_FLUSH, 2'd3);
    step(0, 0, 0, 0); lit("fw_done", C_RUN, 2'd0);

    // Memory wait during LOAD_STALL: remaining bubble resumed
    step(1, 0, 0, 0); lit("lw_c1", C_BUBBLE, 2'd0);
    step(0, 1, 1, 0); lit("lw_frz", C_FREEZE, 2'd1);
    step(0, 0, 1, 1); lit("lw_rdy", C_RUN, 2'd2);
    step(0, 0, 0, 0); lit("lw_resume", C_BUBBLE, 2'd1);
    step(0, 0, 0, 0); lit("lw_done", C_RUN, 2'd0);

    // 6: timeout after MTO wait cycles
    step(0, 0, 1, 0); lit("to_enter", C_FREEZE, 2'd0);
    for (int i = 1; i < MTO; i++) begin
      step(0, 0, 1, 0); lit("to_wait", C_FREEZE, 2'd2);
    end
    step(0, 0, 1, 0); lit("to_release", C_RUN, 2'd2);
    check("to_err_pre", 8'(mem_error), 8'd0);
    step(0, 0, 0, 0); lit("to_run", C_RUN, 2'd0);
    check("to_err", 8'(mem_error), 8'd1);

    // Asynchronous reset in the middle of LOAD_STALL
    step(1, 0, 0, 0); lit("rs_c1", C_BUBBLE, 2'd0);
    step(0, 0, 0, 0); lit("rs_ls", C_BUBBLE, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    lit("rs_async", C_RUN, 2'd0);
    check("rs_err", 8'(mem_error), 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Mixed patterns, checked by the model every cycle
    for (int i = 0; i < 120; i++) begin
      logic [3:0] v;
      v = pat[(i * 3 + i / 8) % 8];
      step(v[3], v[2], v[1], v[0]);
    end
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
